nibble_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder that slices captured operands into 4-bit nibbles, LSB first.

---
 rtl/nibble_serial_adder_pkg.sv | 9 +
 rtl/nibble_serial_adder_cla.sv | 21 ++
 rtl/nibble_serial_adder.sv | 100 ++++++++++
 tb/tb_nibble_serial_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared nibble width and FSM state encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/nibble_serial_adder_cla.sv
// nibble_serial_adder_cla: 4-bit carry-lookahead adder, the single arithmetic slice of the serial adder.
module nibble_serial_adder_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add, one nibble per cycle through a shared CLA, LSB first.
// Optional subtract (a - b, sub port) when NSA_SUB_EN is defined.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N  = WIDTH / NIBBLE_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_r, b_r, res, res_n;
    logic             carry;
    logic [3:0]       a_n, b_n, s_n;
    logic             c_n;
`ifdef NSA_SUB_EN
    logic             sub_r;
    assign b_n = b_r[NIBBLE_W*idx +: NIBBLE_W] ^ {NIBBLE_W{sub_r}};
`else
    assign b_n = b_r[NIBBLE_W*idx +: NIBBLE_W];
`endif
    assign a_n = a_r[NIBBLE_W*idx +: NIBBLE_W];
    // carry is preloaded with the first-nibble carry-in at accept, so the CLA always takes it
    nibble_serial_adder_cla u_cla (
        .a    (a_n),
        .b    (b_n),
        .cin  (carry),
        .sum  (s_n),
        .cout (c_n)
    );
    always_comb begin
        res_n = res;
        res_n[NIBBLE_W*idx +: NIBBLE_W] = s_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            res   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef NSA_SUB_EN
            sub_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_RUN: begin
                    res   <= res_n;
                    carry <= c_n;
                    if (idx == IW'(N - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_n;
                        cout  <= c_n;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        idx   <= '0;
                        a_r   <= a;
                        b_r   <= b;
`ifdef NSA_SUB_EN
                        sub_r <= sub;
                        carry <= sub ? 1'b1 : cin;
`else
                        carry <= cin;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of the nibble-serial adder against plain arithmetic.
module tb_nibble_serial_adder;
    localparam int W = 16;
    localparam int N = W / 4;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0, sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    int checks = 0, errors = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef NSA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, y, input logic c, s);
`ifdef NSA_SUB_EN
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
`endif
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat, output int nb);
        lat = 0;
        nb  = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
        end
    endtask

    task automatic op(input logic [W-1:0] x, y, input logic c, s, input string tag);
        logic [W:0] e;
        int lat, nb;
        e = model(x, y, c, s);
        a = x; b = y; cin = c; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, nb);
        chk({tag, "_latency"}, lat, N);
        chk({tag, "_busy_cycles"}, nb, N);
        chk({tag, "_sum"}, sum, e[W-1:0]);
        chk({tag, "_cout"}, cout, e[W]);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 0);
    endtask

    initial begin
        logic [W:0] e;
        int lat, nb, pulses;
        logic [W-1:0] seen;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(16'h1234, 16'h4321, 1'b0, 1'b0, "basic");
        chk("basic_sum_const", sum, 16'h5555);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
        chk("ripple_cout_const", cout, 1);
        op(16'h0000, 16'h0000, 1'b1, 1'b0, "cin_only");
        chk("cin_only_const", sum, 16'h0001);
        op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "all_ones");
        for (int i = 0; i < 20; i++)
            op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "rand");

        // start re-asserted mid-run must be ignored
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; seen = '0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin pulses++; seen = sum; end
            @(negedge clk);
        end
        chk("ignore_pulses", pulses, 1);
        chk("ignore_sum", seen, 16'h1010);

        // back-to-back: start held in the DONE cycle
        a = 16'h00F0; b = 16'h0F00; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, nb);
        chk("b2b_first_sum", sum, 16'h0FF0);
        a = 16'h0001; b = 16'h0002; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_immediate", busy, 1);
        chk("b2b_done_low", done, 0);
        wait_done(lat, nb);
        chk("b2b_latency", lat, N);
        chk("b2b_sum", sum, 16'h0003);
        @(negedge clk);

        // asynchronous reset during the second nibble edge
        a = 16'hABCD; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("arst_no_done", pulses, 0);
        op(16'h0007, 16'h0008, 1'b0, 1'b0, "after_rst");
        chk("after_rst_const", sum, 16'h000F);

`ifdef NSA_SUB_EN
        op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub");
        chk("sub_const", sum, 16'hFFFE);
        for (int i = 0; i < 10; i++)
            op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, "rand_sub");
`endif
        e = model(16'h8000, 16'h8000, 1'b0, 1'b0);
        op(16'h8000, 16'h8000, 1'b0, 1'b0, "msb_carry");
        chk("msb_carry_model", {cout, sum}, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
